// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode constants and opcode-class helpers for the RISC pipeline control path.
package pipe_ctrl_pkg;

   localparam int unsigned OP_NOP   = 0;
   localparam int unsigned OP_STORE = 3;
   localparam int unsigned OP_BRA   = 21;
   localparam int unsigned OP_BRC   = 22;

   function automatic logic is_branch(input int unsigned op);
      return (op == OP_BRA) || (op == OP_BRC);
   endfunction

   // Everything in 0..24 except NOP, STORE and the two branches writes the register file.
   function automatic logic writes_rf(input int unsigned op);
      return (op != OP_NOP) && (op != OP_STORE) && !is_branch(op) && (op <= 24);
   endfunction

endpackage

// File: rtl/pipe_ctrl_unit.sv
// Configurable-depth control pipeline: carries opcode/rd per stage, raises dm_we at the
// memory stage and rf_we at writeback, with global stall, branch flush and retire counter.
module pipe_ctrl_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int OP_W     = 6,
   parameter int REG_AW   = 5,
   parameter int NSTAGES  = 11,
   parameter int BR_STAGE = 4,
   parameter int DM_STAGE = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [OP_W-1:0]   in_op,
   input  logic [REG_AW-1:0] in_rd,
   output logic              in_ready,
   input  logic              stall,
   input  logic              br_taken,
   output logic              flush,
   output logic              dm_we,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [31:0]       retire_cnt
);

   localparam int WB = NSTAGES - 1;

   generate
      if (!((1 <= BR_STAGE) && (BR_STAGE < DM_STAGE) && (DM_STAGE < NSTAGES - 1))) begin : g_bad_params
         $error("pipe_ctrl_unit: require 1 <= BR_STAGE < DM_STAGE < NSTAGES-1");
      end
   endgenerate

   logic              vld_p [1:WB];
   logic [OP_W-1:0]   op_p  [1:WB];
   logic [REG_AW-1:0] rd_p  [1:WB];

   logic advance;
   logic br_fire;

   assign advance  = ~stall;
   assign br_fire  = vld_p[BR_STAGE] & is_branch(32'(op_p[BR_STAGE])) & br_taken & ~stall;
   assign in_ready = ~stall & ~br_fire;
   assign flush    = br_fire;

   generate
      for (genvar k = 1; k <= WB; k++) begin : g_stage
         // Stages at or younger than the resolving branch are killed when it fires.
         localparam logic KILLABLE = (k <= BR_STAGE);

         logic              v_src;
         logic [OP_W-1:0]   op_src;
         logic [REG_AW-1:0] rd_src;
         logic              v_q;
         logic [OP_W-1:0]   op_q;
         logic [REG_AW-1:0] rd_q;

         if (k == 1) begin : g_head
            assign v_src  = in_valid & in_ready;
            assign op_src = in_op;
            assign rd_src = in_rd;
         end else begin : g_body
            assign v_src  = vld_p[k-1];
            assign op_src = op_p[k-1];
            assign rd_src = rd_p[k-1];
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               v_q <= 1'b0;
            end else if (advance) begin
               v_q <= v_src & ~(br_fire & KILLABLE);
            end
         end

         always_ff @(posedge clk) begin
            if (advance) begin
               op_q <= op_src;
               rd_q <= rd_src;
            end
         end

         assign vld_p[k] = v_q;
         assign op_p[k]  = op_q;
         assign rd_p[k]  = rd_q;
      end
   endgenerate

   // Memory and writeback stage outputs, suppressed while stalled so no write repeats.
   assign dm_we    = vld_p[DM_STAGE] & (op_p[DM_STAGE] == OP_W'(OP_STORE)) & ~stall;
   assign rf_we    = vld_p[WB] & writes_rf(32'(op_p[WB])) & ~stall;
   assign rf_waddr = reset ? rd_p[WB] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         retire_cnt <= 32'd0;
      end else if (vld_p[WB] & ~stall) begin
         retire_cnt <= retire_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: queue-based instruction-age model checked every cycle,
// plus directed scenarios with hand-computed event cycles.
module tb_pipe_ctrl_unit;

   localparam int OP_W = 6, REG_AW = 5, NSTAGES = 11, BR = 4, DM = 6, WB = 10;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              in_valid = 1'b0;
   logic [OP_W-1:0]   in_op = '0;
   logic [REG_AW-1:0] in_rd = '0;
   logic              in_ready;
   logic              stall = 1'b0;
   logic              br_taken = 1'b0;
   logic              flush;
   logic              dm_we;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [31:0]       retire_cnt;

   always #5 clk = ~clk;

   pipe_ctrl_unit #(
      .OP_W(OP_W), .REG_AW(REG_AW), .NSTAGES(NSTAGES), .BR_STAGE(BR), .DM_STAGE(DM)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_rd(in_rd),
      .in_ready(in_ready), .stall(stall), .br_taken(br_taken), .flush(flush),
      .dm_we(dm_we), .rf_we(rf_we), .rf_waddr(rf_waddr), .retire_cnt(retire_cnt)
   );

   typedef struct { int age; int op; int rd; } instr_t;
   instr_t q[$];
   instr_t nq[$];
   instr_t x;
   int m_retire = 0;
   int cyc = 0;
   int n_vec = 0, n_bad = 0;
   int dm_n, dm_cyc, rf_n, rf_cyc, rf_addr, fl_n, fl_cyc, fl_rdy;

   function automatic bit m_writes(int op);
      return op inside {1, 2, [4:20], 23, 24};
   endfunction

   function automatic bit m_branch(int op);
      return (op == 21) || (op == 22);
   endfunction

   task automatic chk(string name, longint act, longint exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Per-cycle model comparison and event logging at the falling edge.
   bit e_fire, e_dm, e_rf, e_rdy;
   int e_addr;
   always @(negedge clk) begin
      if (!reset) begin
         chk("rst_dm_we", dm_we, 0);
         chk("rst_rf_we", rf_we, 0);
         chk("rst_flush", flush, 0);
         chk("rst_rf_waddr", rf_waddr, 0);
         chk("rst_retire", retire_cnt, 0);
         q.delete();
         m_retire = 0;
      end else begin
         e_fire = 0; e_dm = 0; e_rf = 0; e_addr = 0;
         foreach (q[i]) begin
            if (q[i].age == BR && m_branch(q[i].op) && br_taken && !stall) e_fire = 1;
            if (q[i].age == DM && q[i].op == 3 && !stall) e_dm = 1;
            if (q[i].age == WB && m_writes(q[i].op) && !stall) begin
               e_rf = 1; e_addr = q[i].rd;
            end
         end
         e_rdy = !stall && !e_fire;
         chk("in_ready", in_ready, e_rdy);
         chk("flush", flush, e_fire);
         chk("dm_we", dm_we, e_dm);
         chk("rf_we", rf_we, e_rf);
         if (e_rf) chk("rf_waddr", rf_waddr, e_addr);
         chk("retire_cnt", retire_cnt, m_retire);

         if (dm_we) begin dm_n++; dm_cyc = cyc; end
         if (rf_we) begin rf_n++; rf_cyc = cyc; rf_addr = rf_waddr; end
         if (flush) begin fl_n++; fl_cyc = cyc; fl_rdy = in_ready; end

         if (!stall) begin
            nq.delete();
            foreach (q[i]) begin
               x = q[i];
               if (e_fire && x.age < BR) continue;
               if (x.age == WB) begin m_retire++; continue; end
               x.age++;
               nq.push_back(x);
            end
            if (in_valid && e_rdy) begin
               x.age = 1; x.op = int'(in_op); x.rd = int'(in_rd);
               nq.push_back(x);
            end
            q = nq;
         end
      end
   end

   task automatic step(int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clr_log();
      dm_n = 0; dm_cyc = -1; rf_n = 0; rf_cyc = -1; rf_addr = -1;
      fl_n = 0; fl_cyc = -1; fl_rdy = -1;
   endtask

   task automatic do_reset();
      reset = 1'b0; in_valid = 1'b0; stall = 1'b0; br_taken = 1'b0;
      step(2);
      reset = 1'b1;
      step(1);
      clr_log();
   endtask

   int t0, t1;
   initial begin
      clr_log();
      step(1);

      // STORE: dm_we in cycle 6 only, no register write
      do_reset();
      t0 = cyc; in_valid = 1; in_op = 3; in_rd = 2; step(); in_valid = 0;
      step(14);
      chk("st_dm_count", dm_n, 1);
      chk("st_dm_cycle", dm_cyc - t0, 6);
      chk("st_rf_count", rf_n, 0);
      chk("st_retire", retire_cnt, 1);

      // ADD rd=7: rf_we in cycle 10
      do_reset();
      t0 = cyc; in_valid = 1; in_op = 1; in_rd = 7; step(); in_valid = 0;
      step(14);
      chk("add_rf_count", rf_n, 1);
      chk("add_rf_cycle", rf_cyc - t0, 10);
      chk("add_rf_addr", rf_addr, 7);
      chk("add_dm_count", dm_n, 0);
      chk("add_retire", retire_cnt, 1);

      // Stall cycles 4..6 push the write to cycle 13
      do_reset();
      t0 = cyc; in_valid = 1; in_op = 1; in_rd = 3; step(); in_valid = 0;
      step(3);
      stall = 1; step(3); stall = 0;
      step(12);
      chk("stl_rf_count", rf_n, 1);
      chk("stl_rf_cycle", rf_cyc - t0, 13);
      chk("stl_rf_addr", rf_addr, 3);

      // Taken branch at cycle 4 kills ops issued in cycles 1..3
      do_reset();
      t0 = cyc; in_valid = 1; in_op = 21; in_rd = 9; step();
      for (int i = 1; i <= 5; i++) begin
         in_op = 1; in_rd = REG_AW'(i); br_taken = (i == 4); step();
      end
      in_valid = 0; br_taken = 0;
      step(16);
      chk("br_flush_count", fl_n, 1);
      chk("br_flush_cycle", fl_cyc - t0, 4);
      chk("br_ready_at_flush", fl_rdy, 0);
      chk("br_rf_count", rf_n, 1);
      chk("br_rf_cycle", rf_cyc - t0, 15);
      chk("br_rf_addr", rf_addr, 5);
      chk("br_retire", retire_cnt, 2);

      // Stall wins over br_taken; branch fires on the next unstalled cycle
      do_reset();
      t0 = cyc; in_valid = 1; in_op = 22; in_rd = 1; step(); in_valid = 0;
      step(3);
      stall = 1; br_taken = 1; step();
      stall = 0; step();
      br_taken = 0; step(12);
      chk("sb_flush_count", fl_n, 1);
      chk("sb_flush_cycle", fl_cyc - t0, 5);
      chk("sb_retire", retire_cnt, 1);

      // Reset mid-stream discards everything in flight
      do_reset();
      t0 = cyc;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1; in_op = 1; in_rd = REG_AW'(i + 1); step();
      end
      reset = 0; in_valid = 0; #1;
      chk("mr_dm_we", dm_we, 0);
      chk("mr_rf_we", rf_we, 0);
      chk("mr_flush", flush, 0);
      chk("mr_rf_waddr", rf_waddr, 0);
      chk("mr_retire", retire_cnt, 0);
      clr_log();
      step(2); reset = 1;
      step(12);
      chk("mr_quiet_rf", rf_n, 0);
      chk("mr_quiet_retire", retire_cnt, 0);
      t1 = cyc; in_valid = 1; in_op = 1; in_rd = 11; step(); in_valid = 0;
      step(12);
      chk("mr_new_rf_count", rf_n, 1);
      chk("mr_new_rf_cycle", rf_cyc - t1, 10);
      chk("mr_new_rf_addr", rf_addr, 11);

      // Non-writing opcodes and NOP still retire
      do_reset();
      in_valid = 1; in_op = 25; in_rd = 4; step();
      in_op = 63; in_rd = 5; step();
      in_op = 0; in_rd = 6; step();
      in_valid = 0; step(14);
      chk("nw_dm_count", dm_n, 0);
      chk("nw_rf_count", rf_n, 0);
      chk("nw_retire", retire_cnt, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
